// File: rtl/mandel_pixel_dispatcher.sv
// Raster walker for a single Mandelbrot solver: launches one pixel at a time, waits for the
// iteration count, and writes it to the frame buffer.
module mandel_pixel_dispatcher #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [26:0]       cr_init,
  input  logic [26:0]       ci_init,
  input  logic [26:0]       d_r,
  input  logic [26:0]       d_i,
  input  logic [12:0]       max_iter,
  output logic              solver_reset,
  output logic [26:0]       solver_cr,
  output logic [26:0]       solver_ci,
  output logic [12:0]       solver_max_iter,
  input  logic              solver_done,
  input  logic [12:0]       solver_iter,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [12:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [31:0]       frame_cycles
);

  localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] XLast = XW'(H_RES - 1);
  localparam logic [YW-1:0] YLast = YW'(V_RES - 1);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StSolve, StSettle, StWrite, StAdvance, StDone
  } state_e;

  state_e state_q, state_d;

  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [26:0]       cur_r_q, cur_i_q, cr0_q, dr_q, di_q;
  logic [12:0]       mi_q, data_q;
  logic [31:0]       cyc_q;
  logic              first_q;
  logic              last_px;

  assign last_px = (x_q == XLast) && (y_q == YLast);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StLaunch;
      StLaunch:  state_d = StSolve;
      // The solver still sits in its init state on the first cycle, so done may be stale.
      StSolve:   if (!first_q && solver_done) state_d = StSettle;
      StSettle:  state_d = StWrite;
      StWrite:   if (wr_ready) state_d = StAdvance;
      StAdvance: state_d = last_px ? StDone : StLaunch;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      cur_r_q <= '0;
      cur_i_q <= '0;
      cr0_q   <= '0;
      dr_q    <= '0;
      di_q    <= '0;
      mi_q    <= '0;
      data_q  <= '0;
      cyc_q   <= '0;
      first_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            cr0_q   <= cr_init;
            dr_q    <= d_r;
            di_q    <= d_i;
            mi_q    <= max_iter;
            cur_r_q <= cr_init;
            cur_i_q <= ci_init;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            cyc_q   <= '0;
          end
        end
        StLaunch: first_q <= 1'b1;
        StSolve:  first_q <= 1'b0;
        StSettle: data_q  <= solver_iter;
        StAdvance: begin
          if (!last_px) begin
            addr_q <= addr_q + 1'b1;
            if (x_q == XLast) begin
              x_q     <= '0;
              y_q     <= y_q + 1'b1;
              cur_r_q <= cr0_q;
              cur_i_q <= cur_i_q - di_q;
            end else begin
              x_q     <= x_q + 1'b1;
              cur_r_q <= cur_r_q + dr_q;
            end
          end
        end
        default: ;
      endcase
      // Count stops in DONE so the reported value is frozen on the frame_done pulse.
      if (state_q != StIdle && state_q != StDone) cyc_q <= cyc_q + 1'b1;
    end
  end

  assign solver_reset    = reset || (state_q == StLaunch);
  assign solver_cr       = cur_r_q;
  assign solver_ci       = cur_i_q;
  assign solver_max_iter = mi_q;
  assign wr_valid        = (state_q == StWrite);
  assign wr_addr         = addr_q;
  assign wr_data         = data_q;
  assign busy            = (state_q != StIdle);
  assign frame_done      = (state_q == StDone);
  assign frame_cycles    = cyc_q;

endmodule

// File: tb/tb_mandel_pixel_dispatcher.sv
// Bench for mandel_pixel_dispatcher on a 4x2 raster with a behavioural solver and a
// floating-point escape-time reference.
module tb_mandel_pixel_dispatcher;

  localparam int H = 4;
  localparam int V = 2;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [26:0] cr_init = '0, ci_init = '0, d_r = '0, d_i = '0;
  logic [12:0] max_iter = '0;
  logic        solver_reset, solver_done;
  logic [26:0] solver_cr, solver_ci;
  logic [12:0] solver_max_iter, solver_iter;
  logic        wr_valid, busy, frame_done;
  logic        wr_ready = 1'b0;
  logic [2:0]  wr_addr;
  logic [12:0] wr_data;
  logic [31:0] frame_cycles;

  mandel_pixel_dispatcher #(.H_RES(H), .V_RES(V), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cr_init(cr_init), .ci_init(ci_init), .d_r(d_r), .d_i(d_i), .max_iter(max_iter),
    .solver_reset(solver_reset), .solver_cr(solver_cr), .solver_ci(solver_ci),
    .solver_max_iter(solver_max_iter), .solver_done(solver_done), .solver_iter(solver_iter),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_cycles(frame_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Escape-time count: iterate z = z^2 + c until |z|^2 > 4 or the limit is reached.
  function automatic int escape_count(input logic [26:0] cr, input logic [26:0] ci, input int mi);
    int  vr, vi, n;
    real c_r, c_i, zr, zi, t;
    vr = $signed(cr);
    vi = $signed(ci);
    c_r = $itor(vr) / 8388608.0;
    c_i = $itor(vi) / 8388608.0;
    zr = 0.0;
    zi = 0.0;
    n = 0;
    do begin
      t  = zr * zr - zi * zi + c_r;
      zi = 2.0 * zr * zi + c_i;
      zr = t;
      n++;
    end while (n < mi && (zr * zr + zi * zi) <= 4.0);
    return n;
  endfunction

  // Solver: one init cycle after clear (done still stale), then the count takes that many cycles.
  logic sv_done = 1'b0;
  bit   sv_init = 1'b0;
  int   sv_cnt = 0;
  int   sv_t = 0;
  assign solver_done = sv_done;
  assign solver_iter = 13'(sv_t);

  always @(posedge clk) begin
    if (solver_reset) begin
      sv_init <= 1'b1;
      sv_t    <= escape_count(solver_cr, solver_ci, int'(solver_max_iter));
    end else if (sv_init) begin
      sv_init <= 1'b0;
      sv_cnt  <= 0;
      sv_done <= 1'b0;
    end else begin
      sv_cnt  <= sv_cnt + 1;
      sv_done <= (sv_cnt + 1 >= sv_t);
    end
  end

  // Reference frame model.
  logic [26:0] exp_cr[NPIX], exp_ci[NPIX];
  int          exp_data[NPIX], stall_plan[NPIX], wr_log[NPIX];
  int          exp_cycles;
  int          wr_cnt = 0, launch_cnt = 0, done_cnt = 0, wait_cnt = 0;
  logic [31:0] cyc_at_done = '0;
  logic [26:0] launch_cr = '0, launch_ci = '0;
  logic [2:0]  held_addr = '0;
  logic [12:0] held_data = '0;

  always @(negedge clk) begin
    if (solver_reset && !reset) begin
      if (launch_cnt < NPIX) begin
        check("launch_cr", solver_cr, exp_cr[launch_cnt]);
        check("launch_ci", solver_ci, exp_ci[launch_cnt]);
      end
      launch_cr = solver_cr;
      launch_ci = solver_ci;
      launch_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      cyc_at_done = frame_cycles;
    end
  end

  // Write port: ready is held low for the planned number of cycles of each pixel.
  always @(negedge clk) begin
    int plan;
    if (wr_valid) begin
      if (wait_cnt == 0) begin
        held_addr = wr_addr;
        held_data = wr_data;
        check("coord_hold_r", solver_cr, launch_cr);
        check("coord_hold_i", solver_ci, launch_ci);
      end else begin
        check("stall_addr", wr_addr, held_addr);
        check("stall_data", wr_data, held_data);
      end
      plan = (wr_cnt < NPIX) ? stall_plan[wr_cnt] : 0;
      if (wait_cnt >= plan) begin
        wr_ready = 1'b1;
        if (wr_cnt < NPIX) begin
          check("wr_addr", wr_addr, wr_cnt);
          check("wr_data", wr_data, exp_data[wr_cnt]);
          wr_log[wr_cnt] = int'(wr_data);
        end else begin
          check("wr_extra", wr_cnt, NPIX - 1);
        end
        wr_cnt++;
        wait_cnt = 0;
      end else begin
        wr_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      wr_ready = 1'($urandom_range(0, 1));
      wait_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [26:0] cr, input logic [26:0] ci,
                             input logic [26:0] dr, input logic [26:0] di,
                             input logic [12:0] mi);
    exp_cycles = 0;
    for (int k = 0; k < NPIX; k++) begin
      exp_cr[k]   = cr + 27'(k % H) * dr;
      exp_ci[k]   = ci - 27'(k / H) * di;
      exp_data[k] = escape_count(exp_cr[k], exp_ci[k], int'(mi));
      wr_log[k]   = -1;
      exp_cycles += exp_data[k] + 6 + stall_plan[k];
    end
    wr_cnt = 0;
    launch_cnt = 0;
    done_cnt = 0;
    tick();
    cr_init = cr;
    ci_init = ci;
    d_r = dr;
    d_i = di;
    max_iter = mi;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("cycles_cleared", frame_cycles, 0);
    check("max_iter_latched", solver_max_iter, mi);
    cr_init = 27'($urandom);
    ci_init = 27'($urandom);
    d_r = 27'($urandom);
    d_i = 27'($urandom);
    max_iter = 13'($urandom);
  endtask

  task automatic finish_frame(input string tag);
    for (int c = 0; c < 20000 && done_cnt == 0; c++) tick();
    repeat (3) tick();
    check({tag, "_writes"}, wr_cnt, NPIX);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_cycles"}, cyc_at_done, exp_cycles);
    check({tag, "_cycles_frozen"}, frame_cycles, exp_cycles);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_launches(input int n);
    for (int c = 0; c < 20000 && launch_cnt < n; c++) tick();
  endtask

  int cyc_a;

  initial begin
    foreach (stall_plan[k]) stall_plan[k] = 0;
    // Reset and idle.
    repeat (3) tick();
    check("reset_solver_reset", solver_reset, 1);
    reset = 1'b0;
    repeat (10) tick();
    check("idle_busy", busy, 0);
    check("idle_wr_valid", wr_valid, 0);
    check("idle_solver_reset", solver_reset, 0);
    check("idle_frame_cycles", frame_cycles, 0);
    check("idle_frame_done", frame_done, 0);
    check("idle_wr_addr", wr_addr, 0);
    check("idle_solver_cr", solver_cr, 0);

    // Directed small frame.
    start_frame(27'h700_0000, 27'h080_0000, 27'h040_0000, 27'h080_0000, 13'd100);
    finish_frame("frame_a");
    check("px00_count", wr_log[0], 1);
    check("px31_count", wr_log[7], 100);
    cyc_a = int'(cyc_at_done);

    // Same frame with five stalled cycles on pixel 2.
    stall_plan[2] = 5;
    start_frame(27'h700_0000, 27'h080_0000, 27'h040_0000, 27'h080_0000, 13'd100);
    finish_frame("backpressure");
    check("stall_extra_cycles", int'(cyc_at_done) - cyc_a, 5);
    stall_plan[2] = 0;

    // max_iter = 1 on random coordinates.
    start_frame(27'($urandom), 27'($urandom), 27'($urandom), 27'($urandom), 13'd1);
    finish_frame("max_iter_1");
    check("max_iter_1_cycles", cyc_at_done, 56);
    check("max_iter_1_last", wr_log[7], 1);

    // Random frames with random write backpressure.
    for (int r = 0; r < 3; r++) begin
      foreach (stall_plan[k]) stall_plan[k] = $urandom_range(0, 3);
      start_frame(27'($urandom_range(0, 33554431) - 16777216),
                  27'($urandom_range(0, 33554431) - 16777216),
                  27'($urandom_range(0, 4194304)), 27'($urandom_range(0, 4194304)),
                  13'($urandom_range(1, 40)));
      finish_frame("random");
    end
    foreach (stall_plan[k]) stall_plan[k] = 0;

    // Reset during the solve of pixel 5.
    start_frame(27'h700_0000, 27'h080_0000, 27'h040_0000, 27'h080_0000, 13'd100);
    wait_launches(6);
    reset = 1'b1;
    #1;
    check("midreset_solver_reset", solver_reset, 1);
    tick();
    reset = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_wr_valid", wr_valid, 0);
    check("midreset_cycles", frame_cycles, 0);
    check("midreset_addr", wr_addr, 0);
    repeat (30) tick();
    check("midreset_writes", wr_cnt, 5);
    check("midreset_no_done", done_cnt, 0);
    start_frame(27'h700_0000, 27'h080_0000, 27'h040_0000, 27'h080_0000, 13'd100);
    finish_frame("after_reset");

    // Second start mid-frame is ignored.
    start_frame(27'h780_0000, 27'h040_0000, 27'h020_0000, 27'h040_0000, 13'd20);
    wait_launches(3);
    cr_init = 27'h123_4567;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame("start_busy");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
